// File: rtl/picorv32_arb_pkg.sv
// Shared types for the PicoRV32 native-bus memory arbiter.
package picorv32_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_req_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/picorv32_rr_pick.sv
// Two-way request selector: round-robin on "not last" or fixed priority to req[0].
module picorv32_rr_pick #(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = ((RR_ENABLE != 0) && (last == 1'b0)) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory bus, one transaction in flight.
// Optional BUSY watchdog with drain state: define PICORV32_MEM_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int unsigned RR_ENABLE      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picorv32_mem_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  arb_state_t  state_q, state_nxt;
  logic [1:0]  grant_q, grant_nxt;
  logic        last_q, last_nxt;
  logic [1:0]  pick;
  logic        timeout_hit;
  logic [31:0] rsp_data;
  arb_req_t    m0_req, m1_req, sel_req, hold_req, s_req;

  assign m0_req  = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req  = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign sel_req = grant_q[1] ? m1_req : m0_req;

  picorv32_rr_pick #(
    .RR_ENABLE(RR_ENABLE)
  ) u_pick (
    .req  ({m1_valid, m0_valid}),
    .last (last_q),
    .pick (pick)
  );

`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q;
  logic        err_q;
  arb_req_t    drain_q;

  assign timeout_hit = (state_q == BUSY) && !s_ready && (timer_q == TIMER_LAST);
  assign hold_req    = drain_q;
  assign err         = err_q;

  // Timer is held at zero while IDLE so every BUSY period starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      if (state_q == BUSY) timer_q <= timer_q + 16'd1;
      else                 timer_q <= '0;
      if (timeout_hit) begin
        err_q   <= 1'b1;
        drain_q <= sel_req;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign hold_req    = '0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    s_valid   = 1'b0;
    s_req     = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    rsp_data  = timeout_hit ? TIMEOUT_RDATA : s_rdata;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_valid  = 1'b1;
        s_req    = sel_req;
        m0_rdata = grant_q[0] ? rsp_data : '0;
        m1_rdata = grant_q[1] ? rsp_data : '0;
        // A timeout completes the master now but leaves the bus beat pending in DRAIN.
        if (s_ready || timeout_hit) begin
          m0_ready  = grant_q[0];
          m1_ready  = grant_q[1];
          grant_nxt = '0;
          last_nxt  = grant_q[1];
          state_nxt = s_ready ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        s_valid = 1'b1;
        s_req   = hold_req;
        if (s_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign s_instr = s_req.instr;
  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;
  assign s_wstrb = s_req.wstrb;
  assign grant   = grant_q;

endmodule
